fib_datapath: RTL

FIB_DATAPATH -- requirements
Module: fib_datapath

---
 rtl/fib_if.sv | 29 ++
 rtl/fib_datapath.sv | 120 ++++++++++++
 2 files changed

// File: rtl/fib_if.sv
// fib_if: controller-to-datapath bus for fib_datapath.
//   master (controller): drives opcode, R1, R2, N; receives status/result.
//   slave  (datapath)  : receives opcode, R1, R2, N; drives zero_flag,
//                        Result, Result_valid, Ovf.
// Parameters WIDTH (data width) and CNT_W (counter width) must match the
// datapath instance connected to the slave modport.
interface fib_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [2:0]       opcode;
    logic [1:0]       R1;
    logic [1:0]       R2;
    logic [CNT_W-1:0] N;
    logic             zero_flag;
    logic [WIDTH-1:0] Result;
    logic             Result_valid;
    logic             Ovf;

    modport master (
        output opcode, R1, R2, N,
        input  zero_flag, Result, Result_valid, Ovf
    );

    modport slave (
        input  opcode, R1, R2, N,
        output zero_flag, Result, Result_valid, Ovf
    );
endinterface

// File: rtl/fib_datapath.sv
// fib_datapath: 4-entry register file plus an iteration counter, driven
// one opcode per cycle by an external controller (e.g. a Fibonacci loop).
//
// Ports:
//   Clk  - single clock, all state changes on the rising edge
//   Rst  - synchronous active-low reset
//   bus  - fib_if slave: opcode/R1/R2/N in; zero_flag/Result/Result_valid/Ovf out
//
// Opcodes: 000 CLR, 001 LDN, 010 NOP, 011 DEC, 100 LDI, 101 TST, 110 ADD, 111 MOV
//
// Build option: define FIB_DATAPATH_SAT_EN to saturate an overflowing ADD to
// all-ones; otherwise the sum wraps modulo 2^WIDTH. Ovf is set either way.
module fib_datapath #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic Clk,
    input  logic Rst,
    fib_if.slave bus
);

    typedef enum logic [2:0] {
        OP_CLR = 3'b000,
        OP_LDN = 3'b001,
        OP_NOP = 3'b010,
        OP_DEC = 3'b011,
        OP_LDI = 3'b100,
        OP_TST = 3'b101,
        OP_ADD = 3'b110,
        OP_MOV = 3'b111
    } op_e;

    logic [WIDTH-1:0] rf_q [4];
    logic [WIDTH-1:0] rf_d [4];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_flag_q, zero_flag_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   add_sum;

    always_comb begin
        rf_d           = rf_q;
        cnt_d          = cnt_q;
        zero_flag_d    = zero_flag_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        ovf_d          = ovf_q;
        // Extra bit captures the carry; both operands are pre-edge values,
        // so R1==R2 naturally doubles.
        add_sum        = {1'b0, rf_q[bus.R1]} + {1'b0, rf_q[bus.R2]};

        case (op_e'(bus.opcode))
            OP_CLR: begin
                for (int i = 0; i < 4; i++) rf_d[i] = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
                zero_flag_d = 1'b1;
            end
            OP_LDN: begin
                cnt_d = bus.N;
            end
            OP_LDI: begin
                rf_d[bus.R1] = WIDTH'(1);
                rf_d[bus.R2] = WIDTH'(1);
            end
            OP_MOV: begin
                rf_d[bus.R1] = rf_q[bus.R2];
            end
            OP_ADD: begin
                if (add_sum[WIDTH]) begin
                    ovf_d = 1'b1;
`ifdef FIB_DATAPATH_SAT_EN
                    rf_d[bus.R1] = '1;
`else
                    rf_d[bus.R1] = add_sum[WIDTH-1:0];
`endif
                end else begin
                    rf_d[bus.R1] = add_sum[WIDTH-1:0];
                end
            end
            OP_DEC: begin
                // Counter parks at zero rather than wrapping.
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                zero_flag_d = (cnt_q <= CNT_W'(1));
            end
            OP_TST: begin
                zero_flag_d    = (cnt_q == '0);
                result_d       = rf_q[bus.R1];
                result_valid_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
            cnt_q          <= '0;
            zero_flag_q    <= 1'b1;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            rf_q           <= rf_d;
            cnt_q          <= cnt_d;
            zero_flag_q    <= zero_flag_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            ovf_q          <= ovf_d;
        end
    end

    assign bus.zero_flag    = zero_flag_q;
    assign bus.Result       = result_q;
    assign bus.Result_valid = result_valid_q;
    assign bus.Ovf          = ovf_q;

endmodule
